// File: rtl/snake_game_sequencer.sv
// snake_game_sequencer: game-level controller for the snake datapath.
// Owns the game FSM, the move-tick timer, the button direction filter, and the body length and BCD score.
// Optional build macro SPEEDUP_EN: each accepted apple shortens the move period by SPEED_STEP.
// The period never drops below MIN_DIV, and it returns to TICK_DIV at the start of every new game.
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | after reset, waiting for btn_start
// INIT  | single cycle: datapath reloads its start positions
// PLAY  | game running: move ticks, turns and apples honoured
// LOST  | head hit body; outputs frozen until btn_start
// WON   | length reached MAX_LEN; outputs frozen until btn_start
module snake_game_sequencer #(
  parameter int TICK_DIV   = 21200000,
  parameter int MIN_DIV    = 5000000,
  parameter int SPEED_STEP = 500000,
  parameter int MAX_LEN    = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic [3:0] btn_dir,
  input  logic       apple_eaten,
  input  logic       collision,
  output logic       move_tick,
  output logic       load_init,
  output logic [1:0] head_dir,
  output logic       grow,
  output logic [5:0] length,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic       running,
  output logic       lost,
  output logic       won
);

  // Counter and period share one width, wide enough for the speed-up threshold compare as well.
  localparam int CNT_MAX = (MIN_DIV + SPEED_STEP > TICK_DIV) ? (MIN_DIV + SPEED_STEP) : TICK_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_PLAY,
    S_LOST,
    S_WON
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic [1:0]    head_q, head_d;
  logic [1:0]    pend_q, pend_d;
  logic [5:0]    len_q, len_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic          tick_q, tick_d;
  logic          grow_q, grow_d;
  logic          in_play;
  logic [1:0]    req_dir;
  logic          req_ok;

  // Decode a single button press into a heading; a reversal of the committed heading is refused.
  always_comb begin
    req_dir = 2'd0;
    case (btn_dir)
      4'b0001: req_dir = 2'd3;
      4'b0010: req_dir = 2'd2;
      4'b0100: req_dir = 2'd0;
      4'b1000: req_dir = 2'd1;
      default: req_dir = 2'd0;
    endcase
    req_ok = $onehot(btn_dir) && (req_dir != head_q + 2'd2);
  end

  // Next state, move timer, heading, growth and score.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    head_d   = head_q;
    pend_d   = pend_q;
    len_d    = len_q;
    ones_d   = ones_q;
    tens_d   = tens_q;
    tick_d   = 1'b0;
    grow_d   = 1'b0;
    in_play  = 1'b0;

    case (state_q)
      S_IDLE: if (btn_start) state_d = S_INIT;
      S_INIT: state_d = S_PLAY;
      S_PLAY: begin
        if (btn_start)                 state_d = S_INIT;
        else if (collision)            state_d = S_LOST;
        else if (len_q == 6'(MAX_LEN)) state_d = S_WON;
        else                           in_play = 1'b1;
      end
      S_LOST, S_WON: if (btn_start) state_d = S_INIT;
      default: state_d = S_IDLE;
    endcase

    // A new game starts from the reload values, and they are held through the INIT cycle.
    if (state_d == S_INIT || state_q == S_INIT) begin
      cnt_d    = '0;
      period_d = CW'(TICK_DIV);
      head_d   = 2'd0;
      pend_d   = 2'd0;
      len_d    = 6'd1;
      ones_d   = 4'd0;
      tens_d   = 4'd0;
    end

    // The timer only runs while the game stays in PLAY. Leaving PLAY freezes it.
    if (in_play) begin
      // A >= compare keeps the timer bounded if the period shrinks below the current count.
      if (cnt_q >= period_q - CW'(1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        head_d = pend_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end

      if (req_ok) pend_d = req_dir;

      if (apple_eaten) begin
        grow_d = 1'b1;
        len_d  = len_q + 6'd1;
        if (ones_q == 4'd9) begin
          if (tens_q != 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
          end
        end else begin
          ones_d = ones_q + 4'd1;
        end
`ifdef SPEEDUP_EN
        if (period_q >= CW'(MIN_DIV + SPEED_STEP)) period_d = period_q - CW'(SPEED_STEP);
        else                                       period_d = CW'(MIN_DIV);
`endif
      end
    end
  end

  // State and datapath registers. Reset overrides every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= CW'(TICK_DIV);
      head_q   <= 2'd0;
      pend_q   <= 2'd0;
      len_q    <= 6'd1;
      ones_q   <= 4'd0;
      tens_q   <= 4'd0;
      tick_q   <= 1'b0;
      grow_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      head_q   <= head_d;
      pend_q   <= pend_d;
      len_q    <= len_d;
      ones_q   <= ones_d;
      tens_q   <= tens_d;
      tick_q   <= tick_d;
      grow_q   <= grow_d;
    end
  end

  assign move_tick  = tick_q;
  assign grow       = grow_q;
  assign head_dir   = head_q;
  assign length     = len_q;
  assign score_ones = ones_q;
  assign score_tens = tens_q;
  assign load_init  = (state_q == S_INIT);
  assign running    = (state_q == S_PLAY);
  assign lost       = (state_q == S_LOST);
  assign won        = (state_q == S_WON);

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Bench for snake_game_sequencer. It runs two instances on the same stimulus.
// Instance a uses MAX_LEN=4, so it wins quickly. Instance b uses MAX_LEN=63 and keeps playing long enough to exercise the score carry.
// A game-rule model predicts every output on every cycle. Directed checks then pin the model with hand-computed values.
module tb_snake_game_sequencer;

  localparam int TICK = 8;
  localparam int MIND = 4;
  localparam int STEP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic [3:0] btn_dir = 4'b0000;
  logic       apple_eaten = 1'b0;
  logic       collision = 1'b0;

  logic       move_tick_a, load_init_a, grow_a, running_a, lost_a, won_a;
  logic [1:0] head_dir_a;
  logic [5:0] length_a;
  logic [3:0] ones_a, tens_a;
  logic       move_tick_b, load_init_b, grow_b, running_b, lost_b, won_b;
  logic [1:0] head_dir_b;
  logic [5:0] length_b;
  logic [3:0] ones_b, tens_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  snake_game_sequencer #(.TICK_DIV(TICK), .MIN_DIV(MIND), .SPEED_STEP(STEP), .MAX_LEN(4)) dut_a (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_dir(btn_dir),
    .apple_eaten(apple_eaten), .collision(collision),
    .move_tick(move_tick_a), .load_init(load_init_a), .head_dir(head_dir_a), .grow(grow_a),
    .length(length_a), .score_ones(ones_a), .score_tens(tens_a),
    .running(running_a), .lost(lost_a), .won(won_a));

  snake_game_sequencer #(.TICK_DIV(TICK), .MIN_DIV(MIND), .SPEED_STEP(STEP), .MAX_LEN(63)) dut_b (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_dir(btn_dir),
    .apple_eaten(apple_eaten), .collision(collision),
    .move_tick(move_tick_b), .load_init(load_init_b), .head_dir(head_dir_b), .grow(grow_b),
    .length(length_b), .score_ones(ones_b), .score_tens(tens_b),
    .running(running_b), .lost(lost_b), .won(won_b));

  // ---------------- game-rule model ----------------
  localparam int PH_IDLE = 0, PH_INIT = 1, PH_PLAY = 2, PH_LOST = 3, PH_WON = 4;
  int m_ph[2], m_since[2], m_per[2], m_head[2], m_pend[2], m_len[2], m_score[2];
  bit m_tick[2], m_grow[2];

  function automatic int max_len(input int i);
    return (i == 0) ? 4 : 63;
  endfunction

  // Heading requested by the buttons, or -1 when not exactly one is pressed.
  function automatic int btn_heading(input logic [3:0] b);
    case (b)
      4'b0001: return 3;
      4'b0010: return 2;
      4'b0100: return 0;
      4'b1000: return 1;
      default: return -1;
    endcase
  endfunction

  task automatic new_game(input int i);
    m_since[i] = 0; m_per[i] = TICK; m_head[i] = 0; m_pend[i] = 0;
    m_len[i] = 1; m_score[i] = 0;
  endtask

  task automatic model_step(input int i);
    int want;
    int old_head;
    m_tick[i] = 1'b0;
    m_grow[i] = 1'b0;
    if (rst) begin
      m_ph[i] = PH_IDLE;
      new_game(i);
    end else if (m_ph[i] == PH_INIT) begin
      m_ph[i] = PH_PLAY;
      new_game(i);
    end else if (btn_start) begin
      m_ph[i] = PH_INIT;
      new_game(i);
    end else if (m_ph[i] == PH_PLAY) begin
      if (collision) m_ph[i] = PH_LOST;
      else if (m_len[i] == max_len(i)) m_ph[i] = PH_WON;
      else begin
        old_head = m_head[i];
        if (m_since[i] + 1 >= m_per[i]) begin
          m_tick[i] = 1'b1;
          m_since[i] = 0;
          m_head[i] = m_pend[i];
        end else begin
          m_since[i]++;
        end
        want = btn_heading(btn_dir);
        if (want >= 0 && want != (old_head + 2) % 4) m_pend[i] = want;
        if (apple_eaten) begin
          m_grow[i] = 1'b1;
          m_len[i]++;
          if (m_score[i] < 99) m_score[i]++;
`ifdef SPEEDUP_EN
          m_per[i] = (m_per[i] - STEP < MIND) ? MIND : m_per[i] - STEP;
`endif
        end
      end
    end
  endtask

  function automatic logic [21:0] exp_vec(input int i);
    return {m_tick[i], m_ph[i] == PH_INIT, 2'(m_head[i]), m_grow[i], 6'(m_len[i]),
            4'(m_score[i] % 10), 4'(m_score[i] / 10),
            m_ph[i] == PH_PLAY, m_ph[i] == PH_LOST, m_ph[i] == PH_WON};
  endfunction

  // Advance the model on the same edge that the DUTs sample.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // Check every output of both instances against the model, every cycle, mid-period.
  always @(negedge clk) begin
    logic [21:0] act_v;
    logic [21:0] exp_v;
    cycle++;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        act_v = (i == 0) ?
          {move_tick_a, load_init_a, head_dir_a, grow_a, length_a, ones_a, tens_a, running_a, lost_a, won_a} :
          {move_tick_b, load_init_b, head_dir_b, grow_b, length_b, ones_b, tens_b, running_b, lost_b, won_b};
        exp_v = exp_vec(i);
        n_tests++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL model_outputs inst=%0d cycle=%0d got=%h expected=%h", i, cycle, act_v, exp_v);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick(input int which, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((which == 0) ? move_tick_a : move_tick_b) !== 1'b1 && n < 40);
  endtask

  task automatic gap_apple(input int which, output int n);
    apple_eaten = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      apple_eaten = 1'b0;
      n++;
    end while (((which == 0) ? move_tick_a : move_tick_b) !== 1'b1 && n < 40);
  endtask

  task automatic start_game();
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    chk("load_init_pulse", load_init_a, 1);
    chk("init_length", length_a, 1);
    chk("init_score", {ones_a, tens_a}, 0);
    chk("init_head", head_dir_a, 0);
    @(negedge clk);
    chk("load_init_single", load_init_a, 0);
    chk("running_after_init", running_a, 1);
  endtask

  task automatic apple_pulse();
    apple_eaten = 1'b1;
    @(negedge clk);
    apple_eaten = 1'b0;
  endtask

  initial begin
    int n;
    int ticks;
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_length", length_a, 1);
    chk("reset_running", running_a, 0);
    chk("reset_head", head_dir_a, 0);
    chk("reset_score", {ones_a, tens_a}, 0);
    rst = 1'b0;

    // Start, then tick timing.
    start_game();
    wait_tick(0, n);
    chk("first_tick_gap", n, 8);
    wait_tick(0, n);
    chk("tick_period", n, 8);

    // Heading filter.
    btn_dir = 4'b0010; @(negedge clk); btn_dir = 4'b0000;
    wait_tick(0, n);
    chk("reverse_rejected", head_dir_a, 0);
    btn_dir = 4'b0001; @(negedge clk);
    btn_dir = 4'b0010; @(negedge clk); btn_dir = 4'b0000;
    wait_tick(0, n);
    chk("up_then_left", head_dir_a, 3);
    btn_dir = 4'b0011; @(negedge clk);
    btn_dir = 4'b0110; @(negedge clk); btn_dir = 4'b0000;
    wait_tick(0, n);
    chk("multi_bit_ignored", head_dir_a, 3);

    // Three apples reach MAX_LEN on instance a.
    for (int k = 2; k <= 4; k++) begin
      apple_pulse();
      chk("grow_pulse", grow_a, 1);
      chk("length_grow", length_a, k);
      @(negedge clk);
      chk("grow_single", grow_a, 0);
    end
    chk("won_flag", won_a, 1);
    chk("won_score", {tens_a, ones_a}, 8'h03);
    ticks = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (move_tick_a === 1'b1) ticks++;
    end
    chk("no_tick_when_won", ticks, 0);
    chk("won_holds_length", length_a, 4);

    // Restart from WON, then check the period on the instance that keeps playing.
    start_game();
    wait_tick(1, n);
    chk("restart_tick_gap", n, 8);
`ifdef SPEEDUP_EN
    gap_apple(1, n); chk("speedup_gap1", n, 6);
    gap_apple(1, n); chk("speedup_gap2", n, 4);
    gap_apple(1, n); chk("speedup_floor", n, 4);
`else
    gap_apple(1, n); chk("fixed_gap1", n, 8);
    gap_apple(1, n); chk("fixed_gap2", n, 8);
    gap_apple(1, n); chk("fixed_gap3", n, 8);
`endif

    // Collision wins over an apple in the same cycle.
    start_game();
    apple_pulse();
    @(negedge clk);
    chk("pre_collision_length", length_a, 2);
    collision = 1'b1; apple_eaten = 1'b1;
    @(negedge clk);
    collision = 1'b0; apple_eaten = 1'b0;
    chk("lost_flag", lost_a, 1);
    chk("lost_length", length_a, 2);
    chk("lost_score", ones_a, 1);
    chk("lost_no_grow", grow_a, 0);

    // Reset in mid-game beats a simultaneous start.
    start_game();
    apple_pulse();
    repeat (3) @(negedge clk);
    rst = 1'b1; btn_start = 1'b1;
    @(negedge clk);
    rst = 1'b0; btn_start = 1'b0;
    chk("rst_running", running_a, 0);
    chk("rst_load_init", load_init_a, 0);
    chk("rst_length", length_a, 1);
    chk("rst_score", {ones_a, tens_a}, 0);
    @(negedge clk);
    chk("rst_stays_idle", running_a, 0);

    // Score carry 09 -> 10 on instance b.
    start_game();
    for (int k = 1; k <= 10; k++) begin
      apple_pulse();
      if (k == 9) chk("score_09", {tens_b, ones_b}, 8'h09);
      if (k == 10) begin
        chk("score_10", {tens_b, ones_b}, 8'h10);
        chk("length_11", length_b, 11);
        chk("won_ignores_apples", length_a, 4);
      end
      @(negedge clk);
    end

    // Random play checked by the model alone.
    btn_start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 999) == 0);
      btn_start   = ($urandom_range(0, 199) == 0);
      collision   = ($urandom_range(0, 299) == 0);
      apple_eaten = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       btn_dir = 4'b0001 << $urandom_range(0, 3);
        1:       btn_dir = 4'($urandom_range(0, 15));
        default: btn_dir = 4'b0000;
      endcase
      @(negedge clk);
    end
    rst = 1'b0; btn_start = 1'b0; collision = 1'b0; apple_eaten = 1'b0; btn_dir = 4'b0000;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
